race_input_ctrl: RTL and testbench

//  Player-side game controller for the pyonpyon race. Sits between the debounced-free board keys
//  and the box shifter. Synchronises the left/right keys and checks each press against the current
//  box bit. Drives the shifter load/shift controls and counts the player's remaining boxes in BCD.

---
 rtl/race_input_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_race_input_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/race_input_ctrl.sv
// race_input_ctrl: player key path, BCD score keeping and race arbitration for the pyonpyon race.
// Optional wrong-key lockout is built when RACE_INPUT_CTRL_PENALTY_EN is defined.
module race_input_ctrl #(
  parameter int NUM_BOXES      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int PENALTY_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       box,
  input  logic       pc_ended,
  output logic       load_n,
  output logic       shift,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic [1:0] winner,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, P_WIN = 2'd2, PC_WIN = 2'd3} state_t;

  localparam logic [3:0] INIT_ONE = 4'(NUM_BOXES % 10);
  localparam logic [3:0] INIT_TWO = 4'(NUM_BOXES / 10);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_l_q, sync_l_d, sync_r_q, sync_r_d;
  logic                   prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic                   edge_l_q, edge_l_d, edge_r_q, edge_r_d;
  logic                   load_n_q, load_n_d, shift_q, shift_d;
  logic [3:0]             one_q, one_d, two_q, two_d;
  logic [1:0]             winner_q, winner_d;
  logic                   hit, locked_now;

`ifdef RACE_INPUT_CTRL_PENALTY_EN
  localparam int CNT_W = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PENALTY_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d, miss;
  assign locked_now = locked_q;
  assign locked     = locked_q;
`else
  assign locked_now = 1'b0;
  assign locked     = 1'b0;
`endif

  assign load_n    = load_n_q;
  assign shift     = shift_q;
  assign score_one = one_q;
  assign score_two = two_q;
  assign winner    = winner_q;

  // Synchronise the raw keys and register a one-cycle rising-edge pulse per key.
  always_comb begin
    sync_l_d = {sync_l_q[SYNC_STAGES-2:0], key_left};
    sync_r_d = {sync_r_q[SYNC_STAGES-2:0], key_right};
    prev_l_d = sync_l_q[SYNC_STAGES-1];
    prev_r_d = sync_r_q[SYNC_STAGES-1];
    edge_l_d = sync_l_q[SYNC_STAGES-1] & ~prev_l_q;
    edge_r_d = sync_r_q[SYNC_STAGES-1] & ~prev_r_q;
  end

  always_comb begin
    state_d  = state_q;
    load_n_d = load_n_q;
    shift_d  = 1'b0;
    one_d    = one_q;
    two_d    = two_q;
    winner_d = winner_q;
    hit      = 1'b0;
`ifdef RACE_INPUT_CTRL_PENALTY_EN
    cnt_d    = cnt_q;
    locked_d = locked_q;
    miss     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        load_n_d = 1'b0;
        one_d    = INIT_ONE;
        two_d    = INIT_TWO;
        winner_d = 2'b00;
        if (enable) begin
          state_d  = RUN;
          load_n_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (enable) begin
          // box is only valid once the previous shift has settled, so edges during shift are dropped
          hit = ~shift_q & ~locked_now &
                ((edge_l_q & ~edge_r_q & ~box) | (edge_r_q & ~edge_l_q & box));
`ifdef RACE_INPUT_CTRL_PENALTY_EN
          miss = ~shift_q & ~locked_q & (edge_l_q | edge_r_q) & ~hit;
          if (miss) begin
            locked_d = 1'b1;
            cnt_d    = CNT_LOAD;
          end else if (locked_q) begin
            if (cnt_q == '0) begin
              locked_d = 1'b0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else begin
            locked_d = 1'b0;
          end
`endif
          if (hit) begin
            shift_d = 1'b1;
            if (one_q != 4'd0) begin
              one_d = one_q - 4'd1;
            end else if (two_q != 4'd0) begin
              one_d = 4'd9;
              two_d = two_q - 4'd1;
            end else begin
              one_d = one_q;
            end
          end else begin
            shift_d = 1'b0;
          end
          // A final correct press beats a simultaneous pc_ended
          if (hit && one_q == 4'd1 && two_q == 4'd0) begin
            state_d  = P_WIN;
            winner_d = 2'b01;
          end else if (pc_ended) begin
            state_d  = PC_WIN;
            winner_d = 2'b10;
          end else begin
            state_d  = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      P_WIN, PC_WIN: begin
        state_d = state_q;
`ifdef RACE_INPUT_CTRL_PENALTY_EN
        locked_d = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, key path and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sync_l_q <= '0;
      sync_r_q <= '0;
      prev_l_q <= 1'b0;
      prev_r_q <= 1'b0;
      edge_l_q <= 1'b0;
      edge_r_q <= 1'b0;
      load_n_q <= 1'b0;
      shift_q  <= 1'b0;
      one_q    <= INIT_ONE;
      two_q    <= INIT_TWO;
      winner_q <= 2'b00;
`ifdef RACE_INPUT_CTRL_PENALTY_EN
      cnt_q    <= '0;
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_l_q <= sync_l_d;
      sync_r_q <= sync_r_d;
      prev_l_q <= prev_l_d;
      prev_r_q <= prev_r_d;
      edge_l_q <= edge_l_d;
      edge_r_q <= edge_r_d;
      load_n_q <= load_n_d;
      shift_q  <= shift_d;
      one_q    <= one_d;
      two_q    <= two_d;
      winner_q <= winner_d;
`ifdef RACE_INPUT_CTRL_PENALTY_EN
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
`endif
    end
  end

endmodule

// File: tb/tb_race_input_ctrl.sv
// Directed bench for race_input_ctrl: three instances (3, 2 and 32 boxes) with PENALTY_CYCLES=4.
module tb_race_input_ctrl;

`ifdef RACE_INPUT_CTRL_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk;
  logic [2:0] reset, enable, key_left, key_right, box, pc_ended;
  logic       load_n_o [3];
  logic       shift_o  [3];
  logic       locked_o [3];
  logic [3:0] one_o    [3];
  logic [3:0] two_o    [3];
  logic [1:0] win_o    [3];
  int pass_cnt = 0;
  int total    = 0;

  race_input_ctrl #(.NUM_BOXES(3), .SYNC_STAGES(2), .PENALTY_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset[0]), .enable(enable[0]), .key_left(key_left[0]),
    .key_right(key_right[0]), .box(box[0]), .pc_ended(pc_ended[0]), .load_n(load_n_o[0]),
    .shift(shift_o[0]), .score_one(one_o[0]), .score_two(two_o[0]), .winner(win_o[0]),
    .locked(locked_o[0]));

  race_input_ctrl #(.NUM_BOXES(2), .SYNC_STAGES(2), .PENALTY_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset[1]), .enable(enable[1]), .key_left(key_left[1]),
    .key_right(key_right[1]), .box(box[1]), .pc_ended(pc_ended[1]), .load_n(load_n_o[1]),
    .shift(shift_o[1]), .score_one(one_o[1]), .score_two(two_o[1]), .winner(win_o[1]),
    .locked(locked_o[1]));

  race_input_ctrl #(.NUM_BOXES(32), .SYNC_STAGES(2), .PENALTY_CYCLES(4)) dut_c (
    .clk(clk), .reset(reset[2]), .enable(enable[2]), .key_left(key_left[2]),
    .key_right(key_right[2]), .box(box[2]), .pc_ended(pc_ended[2]), .load_n(load_n_o[2]),
    .shift(shift_o[2]), .score_one(one_o[2]), .score_two(two_o[2]), .winner(win_o[2]),
    .locked(locked_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input int d);
    reset[d] = 1'b1; enable[d] = 1'b0; key_left[d] = 1'b0; key_right[d] = 1'b0; pc_ended[d] = 1'b0;
    @(negedge clk);
    reset[d] = 1'b0;
  endtask

  task automatic start_run(input int d);
    enable[d] = 1'b1;
    @(negedge clk);
  endtask

  // which: 0 left, 1 right, 2 both. Observes 12 cycles after driving the key.
  task automatic press(input int d, input int which, input int hold,
                       output int ns, output int first, output int nl);
    ns = 0; first = 0; nl = 0;
    key_left[d]  = (which != 1);
    key_right[d] = (which != 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == hold) begin key_left[d] = 1'b0; key_right[d] = 1'b0; end
      if (shift_o[d]) begin ns++; if (first == 0) first = i; end
      if (locked_o[d]) nl++;
    end
  endtask

  task automatic test_reset;
    do_reset(0);
    total++; if ({load_n_o[0], shift_o[0], two_o[0], one_o[0], win_o[0], locked_o[0]} !== 13'b0_0_0000_0011_00_0)
      $display("FAIL reset_state got=%b exp=%b", {load_n_o[0], shift_o[0], two_o[0], one_o[0], win_o[0], locked_o[0]}, 13'b0_0_0000_0011_00_0);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if ({load_n_o[0], shift_o[0], two_o[0], one_o[0], win_o[0]} !== 12'b0_0_0000_0011_00)
        $display("FAIL idle_hold cyc=%0d got=%b exp=%b", i, {load_n_o[0], shift_o[0], two_o[0], one_o[0], win_o[0]}, 12'b0_0_0000_0011_00);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_press;
    int ns, first, nl;
    start_run(0);
    total++; if (load_n_o[0] !== 1'b1) $display("FAIL load_n_run got=%b exp=1", load_n_o[0]); else pass_cnt++;
    box[0] = 1'b1;
    press(0, 1, 5, ns, first, nl);
    total++; if (ns !== 1) $display("FAIL single_shift_count got=%0d exp=1", ns); else pass_cnt++;
    total++; if (first !== 4) $display("FAIL single_shift_latency got=%0d exp=4", first); else pass_cnt++;
    total++; if ({two_o[0], one_o[0]} !== 8'h02) $display("FAIL single_score got=%h exp=02", {two_o[0], one_o[0]}); else pass_cnt++;
    press(0, 1, 10, ns, first, nl);
    total++; if (ns !== 1) $display("FAIL held_no_repeat got=%0d exp=1", ns); else pass_cnt++;
    total++; if ({two_o[0], one_o[0]} !== 8'h01) $display("FAIL held_score got=%h exp=01", {two_o[0], one_o[0]}); else pass_cnt++;
  endtask

  task automatic test_penalty;
    int ns, first, nl;
    do_reset(0);
    start_run(0);
    box[0] = 1'b0;
    ns = 0; first = 0; nl = 0;
    key_right[0] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) key_right[0] = 1'b0;
      if (i == 2) key_left[0] = 1'b1;
      if (i == 3) key_left[0] = 1'b0;
      if (shift_o[0]) begin ns++; if (first == 0) first = i; end
      if (locked_o[0]) nl++;
    end
    total++; if (nl !== (PEN ? 4 : 0)) $display("FAIL lock_cycles got=%0d exp=%0d", nl, (PEN ? 4 : 0)); else pass_cnt++;
    total++; if (ns !== (PEN ? 0 : 1)) $display("FAIL lock_drop_shift got=%0d exp=%0d", ns, (PEN ? 0 : 1)); else pass_cnt++;
    total++; if (first !== (PEN ? 0 : 6)) $display("FAIL lock_drop_first got=%0d exp=%0d", first, (PEN ? 0 : 6)); else pass_cnt++;
    total++; if (one_o[0] !== (PEN ? 4'd3 : 4'd2)) $display("FAIL lock_score got=%0d exp=%0d", one_o[0], (PEN ? 3 : 2)); else pass_cnt++;
    press(0, 0, 2, ns, first, nl);
    total++; if (ns !== 1) $display("FAIL after_lock_shift got=%0d exp=1", ns); else pass_cnt++;
    total++; if (one_o[0] !== (PEN ? 4'd2 : 4'd1)) $display("FAIL after_lock_score got=%0d exp=%0d", one_o[0], (PEN ? 2 : 1)); else pass_cnt++;
  endtask

  task automatic test_full_race;
    int ns, first, nl;
    logic [2:0] boxes;
    logic [7:0] exp_sc;
    boxes = 3'b010;
    do_reset(0);
    start_run(0);
    for (int p = 0; p < 3; p++) begin
      box[0] = boxes[p];
      press(0, int'(boxes[p]), 3, ns, first, nl);
      exp_sc = 8'(2 - p);
      total++; if (ns !== 1 || {two_o[0], one_o[0]} !== exp_sc)
        $display("FAIL race_press%0d got shifts=%0d score=%h exp shifts=1 score=%h", p, ns, {two_o[0], one_o[0]}, exp_sc);
      else pass_cnt++;
    end
    total++; if (win_o[0] !== 2'b01) $display("FAIL race_winner got=%b exp=01", win_o[0]); else pass_cnt++;
    pc_ended[0] = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (win_o[0] !== 2'b01 || shift_o[0] !== 1'b0) $display("FAIL race_pc_late got win=%b shift=%b exp win=01 shift=0", win_o[0], shift_o[0]); else pass_cnt++;
    pc_ended[0] = 1'b0;
  endtask

  task automatic test_pc_wins;
    int ns, first, nl;
    do_reset(1);
    start_run(1);
    total++; if ({two_o[1], one_o[1]} !== 8'h02) $display("FAIL pc_start_score got=%h exp=02", {two_o[1], one_o[1]}); else pass_cnt++;
    pc_ended[1] = 1'b1;
    @(negedge clk);
    total++; if (win_o[1] !== 2'b10) $display("FAIL pc_winner got=%b exp=10", win_o[1]); else pass_cnt++;
    pc_ended[1] = 1'b0;
    box[1] = 1'b1;
    press(1, 1, 3, ns, first, nl);
    total++; if (ns !== 0 || win_o[1] !== 2'b10) $display("FAIL pc_terminal got shifts=%0d win=%b exp shifts=0 win=10", ns, win_o[1]); else pass_cnt++;
    // second run: last correct press coincides with pc_ended
    do_reset(1);
    start_run(1);
    box[1] = 1'b0;
    press(1, 0, 3, ns, first, nl);
    total++; if (one_o[1] !== 4'd1) $display("FAIL tie_pre_score got=%0d exp=1", one_o[1]); else pass_cnt++;
    box[1] = 1'b1;
    ns = 0; first = 0;
    key_right[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) pc_ended[1] = 1'b1;
      if (i == 5) key_right[1] = 1'b0;
      if (shift_o[1]) begin ns++; if (first == 0) first = i; end
    end
    pc_ended[1] = 1'b0;
    total++; if (ns !== 1 || first !== 4) $display("FAIL tie_shift got n=%0d first=%0d exp n=1 first=4", ns, first); else pass_cnt++;
    total++; if (win_o[1] !== 2'b01) $display("FAIL tie_winner got=%b exp=01", win_o[1]); else pass_cnt++;
    total++; if ({two_o[1], one_o[1]} !== 8'h00) $display("FAIL tie_score got=%h exp=00", {two_o[1], one_o[1]}); else pass_cnt++;
  endtask

  task automatic test_wide_score;
    int ns, first, nl;
    logic [2:0] boxes;
    logic [7:0] exp_sc [3];
    boxes = 3'b101;
    exp_sc[0] = 8'h31; exp_sc[1] = 8'h30; exp_sc[2] = 8'h29;
    do_reset(2);
    total++; if ({two_o[2], one_o[2]} !== 8'h32) $display("FAIL wide_reset got=%h exp=32", {two_o[2], one_o[2]}); else pass_cnt++;
    start_run(2);
    for (int p = 0; p < 3; p++) begin
      box[2] = boxes[p];
      press(2, int'(boxes[p]), 3, ns, first, nl);
      total++; if ({two_o[2], one_o[2]} !== exp_sc[p]) $display("FAIL wide_bcd%0d got=%h exp=%h", p, {two_o[2], one_o[2]}, exp_sc[p]); else pass_cnt++;
    end
    press(2, 2, 3, ns, first, nl);
    total++; if (ns !== 0 || {two_o[2], one_o[2]} !== 8'h29) $display("FAIL both_keys got shifts=%0d score=%h exp shifts=0 score=29", ns, {two_o[2], one_o[2]}); else pass_cnt++;
    total++; if (nl !== (PEN ? 4 : 0)) $display("FAIL both_keys_lock got=%0d exp=%0d", nl, (PEN ? 4 : 0)); else pass_cnt++;
    enable[2] = 1'b0;
    box[2] = 1'b1;
    press(2, 1, 3, ns, first, nl);
    total++; if (ns !== 0 || {two_o[2], one_o[2]} !== 8'h29 || load_n_o[2] !== 1'b1)
      $display("FAIL freeze got shifts=%0d score=%h load_n=%b exp shifts=0 score=29 load_n=1", ns, {two_o[2], one_o[2]}, load_n_o[2]);
    else pass_cnt++;
    start_run(2);
    box[2] = 1'b1;
    key_left[2] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) key_left[2] = 1'b0;
    end
    total++; if (locked_o[2] !== PEN) $display("FAIL mid_lock got=%b exp=%b", locked_o[2], PEN); else pass_cnt++;
    reset[2] = 1'b1; enable[2] = 1'b0;
    @(negedge clk);
    reset[2] = 1'b0;
    total++; if ({load_n_o[2], locked_o[2], win_o[2], two_o[2], one_o[2]} !== 12'b0_0_00_0011_0010)
      $display("FAIL mid_lock_reset got=%b exp=%b", {load_n_o[2], locked_o[2], win_o[2], two_o[2], one_o[2]}, 12'b0_0_00_0011_0010);
    else pass_cnt++;
    start_run(2);
    press(2, 1, 3, ns, first, nl);
    total++; if (ns !== 1 || {two_o[2], one_o[2]} !== 8'h31) $display("FAIL post_reset_press got shifts=%0d score=%h exp shifts=1 score=31", ns, {two_o[2], one_o[2]}); else pass_cnt++;
  endtask

  initial begin
    reset = 3'b111; enable = 3'b000; key_left = 3'b000; key_right = 3'b000;
    box = 3'b000; pc_ended = 3'b000;
    repeat (2) @(negedge clk);
    reset = 3'b000;
    test_reset();
    test_single_press();
    test_penalty();
    test_full_race();
    test_pc_wins();
    test_wide_score();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
